// File: rtl/adder_operand_loader.sv
// Byte-serial operand loader for a combinational N-bit adder: assembles A then B
// little-endian, presents the pair until accepted, then registers the sum.
module adder_operand_loader #(
  parameter int N = 32,
  localparam int BYTES = N / 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_data,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] op_a,
  output logic [N-1:0] op_b,
  input  logic [N-1:0] sum_in,
  output logic [N-1:0] result,
  output logic         result_valid,
  output logic [15:0]  pair_count,
  output logic [1:0]   state_dbg
);

  // Handshakes: a byte moves when in_valid & in_ready at a rising edge; a pair
  // moves when out_valid & out_ready at a rising edge. in_ready and out_valid
  // depend only on state, never on the partner's valid/ready.

  localparam int CW = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    PRESENT = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          load_a, load_b, accept;
  logic          last_byte;

  assign state_dbg = state;
  assign last_byte = (cnt == CW'(BYTES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= LOAD_A;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    load_a     = 1'b0;
    load_b     = 1'b0;
    accept     = 1'b0;
    case (state)
      LOAD_A: begin
        in_ready = 1'b1;
        if (flush) begin
          cnt_next = '0;
        end else if (in_valid) begin
          load_a = 1'b1;
          if (last_byte) begin
            cnt_next   = '0;
            state_next = LOAD_B;
          end else begin
            cnt_next = cnt + CW'(1);
          end
        end
      end
      LOAD_B: begin
        in_ready = 1'b1;
        // Flush abandons the whole pair, including the already-loaded A.
        if (flush) begin
          cnt_next   = '0;
          state_next = LOAD_A;
        end else if (in_valid) begin
          load_b = 1'b1;
          if (last_byte) begin
            cnt_next   = '0;
            state_next = PRESENT;
          end else begin
            cnt_next = cnt + CW'(1);
          end
        end
      end
      PRESENT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          accept     = 1'b1;
          cnt_next   = '0;
          state_next = LOAD_A;
        end
      end
      default: begin
        cnt_next   = '0;
        state_next = LOAD_A;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_a         <= '0;
      op_b         <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      pair_count   <= '0;
    end else begin
      if (load_a) op_a[{cnt, 3'b000} +: 8] <= in_data;
      if (load_b) op_b[{cnt, 3'b000} +: 8] <= in_data;
      result_valid <= accept;
      if (accept) begin
        result     <= sum_in;
        pair_count <= pair_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_adder_operand_loader.sv
// Directed bench for adder_operand_loader: an inline model of the adder drives
// sum_in; every expected value below is a hand-computed constant.
module tb_adder_operand_loader;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] sum_in;
  logic [31:0] result;
  logic        result_valid;
  logic [15:0] pair_count;
  logic [1:0]  state_dbg;

  int vectors;
  int miscompares;

  adder_operand_loader #(.N(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .op_a         (op_a),
    .op_b         (op_b),
    .sum_in       (sum_in),
    .result       (result),
    .result_valid (result_valid),
    .pair_count   (pair_count),
    .state_dbg    (state_dbg)
  );

  // The combinational adder this stage feeds.
  assign sum_in = op_a + op_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one byte and hold until it transfers; in_valid is left high.
  task automatic send_byte(input logic [7:0] b);
    int n;
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
    step();
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    logic [31:0] v;
    int gap;
    v = w;
    for (int i = 0; i < 4; i++) begin
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        step();
      end
      send_byte(v[8*i +: 8]);
    end
  endtask

  task automatic handshake(input string tag, input logic [31:0] exp_res, input logic [15:0] exp_cnt);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
    step();
    chk({tag, "_result"}, result, exp_res);
    chk({tag, "_result_valid"}, {31'd0, result_valid}, 32'd1);
    chk({tag, "_pair_count"}, {16'd0, pair_count}, {16'd0, exp_cnt});
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    step();
    chk({tag, "_strobe_end"}, {31'd0, result_valid}, 32'd0);
    chk({tag, "_result_hold"}, result, exp_res);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_op_a"}, op_a, 32'd0);
    chk({tag, "_op_b"}, op_b, 32'd0);
    chk({tag, "_result"}, result, 32'd0);
    chk({tag, "_result_valid"}, {31'd0, result_valid}, 32'd0);
    chk({tag, "_pair_count"}, {16'd0, pair_count}, 32'd0);
    chk({tag, "_state"}, {30'd0, state_dbg}, 32'd0);
  endtask

  initial begin
    logic [31:0] ga [3];
    logic [31:0] gb [3];
    logic [31:0] gs [3];
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    in_valid    = 1'b0;
    in_data     = 8'h00;
    flush       = 1'b0;
    out_ready   = 1'b0;
    #12;
    check_reset_values("reset");
    reset = 1'b0;
    step();

    // Basic pair with in_valid held high: out_valid the cycle after byte 8.
    out_ready = 1'b1;
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
    chk("basic_not_yet_valid", {31'd0, out_valid}, 32'd0);
    send_byte(8'h00);
    chk("basic_op_a", op_a, 32'h12345678);
    chk("basic_op_b", op_b, 32'h00000001);
    handshake("basic", 32'h12345679, 16'd1);

    // Overflow wraps; carry is invisible here.
    send_word(32'hFFFFFFFF, 0);
    send_word(32'h00000001, 0);
    handshake("ovf", 32'h00000000, 16'd2);

    // Backpressure: pair held, no bytes consumed.
    out_ready = 1'b0;
    send_word(32'h44332211, 0);
    send_word(32'h88776655, 0);
    in_valid = 1'b1;
    in_data  = 8'h99;
    for (int c = 0; c < 5; c++) begin
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_op_a", op_a, 32'h44332211);
      chk("bp_op_b", op_b, 32'h88776655);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      step();
    end
    handshake("bp", 32'hCCAA8866, 16'd3);
    out_ready = 1'b0;
    send_byte(8'h5A);
    in_valid = 1'b0;
    chk("bp_next_byte_a", op_a, 32'h4433225A);

    // Flush after 2 bytes of B; the flush-cycle byte is dropped.
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    send_byte(8'hE1); send_byte(8'hE2);
    in_valid = 1'b1;
    in_data  = 8'hEE;
    flush    = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_state", {30'd0, state_dbg}, 32'd0);
    chk("flush_op_b", op_b, 32'h8877E2E1);
    chk("flush_pair_count", {16'd0, pair_count}, 32'd3);
    chk("flush_result", result, 32'hCCAA8866);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    chk("flush_new_op_a", op_a, 32'hDDCCBBAA);
    chk("flush_new_op_b", op_b, 32'h04030201);
    handshake("flush", 32'hE1CFBDAB, 16'd4);

    // Flush while presenting is ignored.
    out_ready = 1'b0;
    send_word(32'h00000010, 0);
    send_word(32'h00000020, 0);
    in_valid = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("pflush_out_valid", {31'd0, out_valid}, 32'd1);
    handshake("pflush", 32'h00000030, 16'd5);

    // Asynchronous reset between edges after 3 bytes of A.
    out_ready = 1'b0;
    send_byte(8'h10); send_byte(8'h20); send_byte(8'h30);
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_reset_values("async_rst");
    #2;
    reset = 1'b0;
    step();
    send_word(32'h01020304, 0);
    send_word(32'h40302010, 0);
    chk("post_rst_op_a", op_a, 32'h01020304);
    chk("post_rst_op_b", op_b, 32'h40302010);
    handshake("post_rst", 32'h41322314, 16'd1);

    // Three pairs with random idle gaps, counted from a fresh reset.
    reset = 1'b1;
    #2;
    reset = 1'b0;
    step();
    ga[0] = 32'h0000FFFF; gb[0] = 32'h00000001; gs[0] = 32'h00010000;
    ga[1] = 32'h80000000; gb[1] = 32'h80000000; gs[1] = 32'h00000000;
    ga[2] = 32'hCAFEBABE; gb[2] = 32'h01010101; gs[2] = 32'hCBFFBBBF;
    for (int p = 0; p < 3; p++) begin
      out_ready = 1'b0;
      send_word(ga[p], 3);
      send_word(gb[p], 3);
      in_valid = 1'b0;
      chk("gap_op_a", op_a, ga[p]);
      chk("gap_op_b", op_b, gb[p]);
      handshake("gap", gs[p], 16'(p + 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/adder_operand_loader.md
Name: adder_operand_loader

Overview:
- Upstream feeder stage for the combinational N_bit_adder.
- Accepts a byte-serial stream over a valid/ready handshake and assembles two N-bit operands, A then B, little-endian.
- Presents the operand pair to the adder and holds it until the downstream consumer accepts it.
- Registers the adder's sum on acceptance and reports it with a one-cycle result strobe.

Parameters:
- N, 32, operand width in bits; must be a multiple of 8 and at least 8.
- BYTES, N/8, bytes per operand; derived, never overridden.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_data holds a valid byte.
- in_ready  out  1  stage accepts a byte this cycle.
- in_data  in  8  operand byte, least-significant byte first.
- flush  in  1  synchronous abort of a partially loaded pair.
- out_valid  out  1  op_a/op_b hold a complete pair.
- out_ready  in  1  consumer accepts the pair this cycle.
- op_a  out  N  operand A, drives adder input1.
- op_b  out  N  operand B, drives adder input2.
- sum_in  in  N  adder answer output, combinational from op_a/op_b.
- result  out  N  registered sum of the last accepted pair.
- result_valid  out  1  one-cycle strobe, result updated.
- pair_count  out  16  number of pairs accepted since reset; wraps at 16 bits.

Behaviour:
- Reset (asynchronous): state=LOAD_A, byte counter=0. Outputs in_ready=1, out_valid=0, op_a=0, op_b=0, result=0, result_valid=0, pair_count=0. Reset mid-operation discards all partial data.
- FSM states: LOAD_A, LOAD_B, PRESENT.
- Byte transfer: occurs when in_valid and in_ready are both 1 at a rising edge.
- in_ready: 1 in LOAD_A and LOAD_B, 0 in PRESENT. It depends only on state, not on in_valid.
- LOAD_A: byte k (counter value) is written to op_a[8k+7:8k]. The counter increments; on the transfer with counter=BYTES-1 the counter clears and the FSM goes to LOAD_B.
- LOAD_B: same as LOAD_A, but into op_b. On the last byte the FSM goes to PRESENT.
- Byte lanes: unwritten byte lanes keep their previous values. Every lane is overwritten before the next presentation, so this has no visible effect.
- PRESENT: out_valid=1; op_a/op_b are stable and unchanged until the handshake.
- Handshake (out_valid & out_ready at an edge):
  - result <= sum_in;
  - result_valid=1 for exactly the next cycle;
  - pair_count += 1 (wraps 0xFFFF -> 0);
  - FSM -> LOAD_A, counter=0.
  - No byte is accepted in the handshake cycle, since in_ready=0 in PRESENT.
- Latency: out_valid rises the cycle after the 2*BYTES-th byte transfer. The minimum pair period is 2*BYTES+1 cycles.
- Width/arithmetic: the block does no arithmetic. result is the N-bit sum captured exactly; the adder's carry-out is not observed, so overflow wraps modulo 2^N.
- flush (LOAD_A or LOAD_B):
  - FSM -> LOAD_A, counter=0;
  - a byte presented in the same cycle is dropped;
  - result and pair_count are unchanged.
- flush in PRESENT: ignored; the pair must be consumed.
- in_valid low in a load state: no change; gaps between bytes are allowed.
- out_ready high outside PRESENT: ignored.
- result holds its value between handshakes; result_valid is 0 except on the strobe cycle.

Test Plan:
- N=32. Bytes 78,56,34,12 then 01,00,00,00 with in_valid held high, out_ready=1 -> op_a=0x12345678, op_b=0x00000001, out_valid on cycle 9. Adder sum_in=0x12345679 -> result=0x12345679, result_valid pulses 1 cycle, pair_count=1.
- Overflow: A=0xFFFFFFFF, B=0x00000001 -> result=0x00000000, pair_count increments; the carry is not visible at this stage.
- Backpressure: after a pair loads, hold out_ready=0 for 5 cycles with in_valid=1 and new bytes applied. Required: in_ready=0, op_a/op_b unchanged, no byte consumed. After out_ready=1: handshake, then the next bytes load into op_a.
- Flush: after 2 bytes of B, assert flush with in_valid=1 -> FSM returns to LOAD_A and the flush-cycle byte is dropped. A fresh 8 bytes AA,BB,CC,DD,01,02,03,04 -> op_a=0xDDCCBBAA, op_b=0x04030201.
- Reset mid-load: assert reset asynchronously (between edges) after 3 bytes of A -> all outputs return to reset values immediately. A subsequent full pair loads correctly.
- Gapped input: bytes with random in_valid gaps (0-3 idle cycles) over 3 consecutive pairs -> operands are correct for each pair and pair_count=3.
